// File: rtl/cells_update_sequencer_pkg.sv
// Shared types and defaults for the cells update sequencer and its arbiter.
package cells_update_sequencer_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned TmoWDefault  = 24;

  typedef logic [DataWDefault-1:0] pattern_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish,
    StErr
  } seq_state_e;

  // A pass count of zero still means one full sweep per frame.
  function automatic logic [3:0] eff_passes(input logic [3:0] passes);
    return (passes == 4'd0) ? 4'd1 : passes;
  endfunction

endpackage

// File: rtl/cells_update_sequencer_rr_arbiter2.sv
// Two-requester round-robin arbiter; the last-grant pointer resets to 1 so req 0 wins
// the first tie.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_id_o = 1'b0;
    unique case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ~last_q;
      default: gnt_id_o = 1'b0;
    endcase
    gnt_o  = (req_i == 2'b00) ? 2'b00 : (gnt_id_o ? 2'b10 : 2'b01);
    last_d = accept_i ? gnt_id_o : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cells_update_sequencer.sv
// Frame sequencer for the cells controller: arbitrates two pattern sources, freezes the
// frame configuration and counts update_done sweeps. Optional timeout: SEQ_TIMEOUT_EN.
module cells_update_sequencer
  import cells_update_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned TMO_W  = TmoWDefault
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [31:0]       cfg_ccr0,
  input  logic [31:0]       cfg_ccr1,
  input  logic [3:0]        cfg_passes,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic              force_full,
  input  logic              abort,
  input  logic              update_done,
  output logic [DATA_W-1:0] cells_state,
  output logic [31:0]       ccr0,
  output logic [31:0]       ccr1,
  output logic              system_enable_n,
  output logic              enable_sn,
  output logic              busy,
  output logic              grant_id,
  output logic              frame_done,
  output logic              aborted,
  output logic              timeout_err
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] cells_q, cells_d;
  logic [31:0]       ccr0_q, ccr0_d;
  logic [31:0]       ccr1_q, ccr1_d;
  logic              sen_n_q, sen_n_d;
  logic              en_sn_q, en_sn_d;
  logic              busy_q, busy_d;
  logic              gid_q, gid_d;
  logic              done_q, done_d;
  logic              abrt_q, abrt_d;
  logic              tmo_err_q, tmo_err_d;
  logic              first_q, first_d;
  logic              upd_prev_q, upd_prev_d;
  logic [3:0]        pass_cnt_q, pass_cnt_d;
  logic [3:0]        passes_q, passes_d;

`ifdef SEQ_TIMEOUT_EN
  logic [TMO_W-1:0]  run_cnt_q, run_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`else
  logic              unused_timeout;
  assign unused_timeout = ^cfg_timeout;
`endif

  logic [1:0] gnt;
  logic       gnt_id;
  logic       idle;
  logic       accept;
  logic       rise;
  logic [3:0] pass_sum;

  rr_arbiter2 u_arb (
    .clk_i    (clock),
    .rst_i    (reset),
    .req_i    ({req1_valid, req0_valid}),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign idle       = (state_q == StIdle);
  assign req0_ready = idle & gnt[0];
  assign req1_ready = idle & gnt[1];
  assign accept     = idle & (gnt != 2'b00);

  // update_done is a level that lasts several cycles; only its rising edge is a pass.
  assign rise     = update_done & ~upd_prev_q;
  assign pass_sum = pass_cnt_q + 4'(rise);

  always_comb begin
    state_d    = state_q;
    cells_d    = cells_q;
    ccr0_d     = ccr0_q;
    ccr1_d     = ccr1_q;
    sen_n_d    = sen_n_q;
    en_sn_d    = en_sn_q;
    busy_d     = busy_q;
    gid_d      = gid_q;
    done_d     = 1'b0;
    abrt_d     = 1'b0;
    tmo_err_d  = tmo_err_q;
    first_d    = first_q;
    upd_prev_d = update_done;
    pass_cnt_d = pass_cnt_q;
    passes_d   = passes_q;
`ifdef SEQ_TIMEOUT_EN
    run_cnt_d  = run_cnt_q;
    tmo_d      = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StRun;
          cells_d    = gnt_id ? req1_data : req0_data;
          ccr0_d     = cfg_ccr0;
          ccr1_d     = cfg_ccr1;
          gid_d      = gnt_id;
          sen_n_d    = 1'b0;
          busy_d     = 1'b1;
          en_sn_d    = first_q | force_full;
          first_d    = 1'b0;
          pass_cnt_d = 4'd0;
          passes_d   = eff_passes(cfg_passes);
`ifdef SEQ_TIMEOUT_EN
          run_cnt_d  = '0;
          tmo_d      = cfg_timeout;
`endif
        end
      end
      StRun: begin
        // Abort outranks a final sweep edge arriving in the same cycle.
        if (abort) begin
          state_d = StIdle;
          sen_n_d = 1'b1;
          busy_d  = 1'b0;
          abrt_d  = 1'b1;
        end else if (pass_sum == passes_q) begin
          state_d    = StFinish;
          sen_n_d    = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          pass_cnt_d = pass_sum;
        end else begin
          pass_cnt_d = pass_sum;
`ifdef SEQ_TIMEOUT_EN
          run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + TMO_W'(1);
          if ((tmo_q != '0) && (run_cnt_d == tmo_q)) begin
            state_d   = StErr;
            sen_n_d   = 1'b1;
            busy_d    = 1'b0;
            tmo_err_d = 1'b1;
          end
`endif
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
`ifdef SEQ_TIMEOUT_EN
      StErr: begin
        state_d = StErr;
      end
`endif
      default: begin
        state_d = StIdle;
        sen_n_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cells_q    <= '0;
      ccr0_q     <= '0;
      ccr1_q     <= '0;
      sen_n_q    <= 1'b1;
      en_sn_q    <= 1'b1;
      busy_q     <= 1'b0;
      gid_q      <= 1'b0;
      done_q     <= 1'b0;
      abrt_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      first_q    <= 1'b1;
      upd_prev_q <= 1'b0;
      pass_cnt_q <= 4'd0;
      passes_q   <= 4'd1;
`ifdef SEQ_TIMEOUT_EN
      run_cnt_q  <= '0;
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cells_q    <= cells_d;
      ccr0_q     <= ccr0_d;
      ccr1_q     <= ccr1_d;
      sen_n_q    <= sen_n_d;
      en_sn_q    <= en_sn_d;
      busy_q     <= busy_d;
      gid_q      <= gid_d;
      done_q     <= done_d;
      abrt_q     <= abrt_d;
      tmo_err_q  <= tmo_err_d;
      first_q    <= first_d;
      upd_prev_q <= upd_prev_d;
      pass_cnt_q <= pass_cnt_d;
      passes_q   <= passes_d;
`ifdef SEQ_TIMEOUT_EN
      run_cnt_q  <= run_cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign cells_state     = cells_q;
  assign ccr0            = ccr0_q;
  assign ccr1            = ccr1_q;
  assign system_enable_n = sen_n_q;
  assign enable_sn       = en_sn_q;
  assign busy            = busy_q;
  assign grant_id        = gid_q;
  assign frame_done      = done_q;
  assign aborted         = abrt_q;
`ifdef SEQ_TIMEOUT_EN
  assign timeout_err     = tmo_err_q;
`else
  logic unused_tmo_err;
  assign unused_tmo_err  = tmo_err_q;
  assign timeout_err     = 1'b0;
`endif

endmodule

// File: doc/cells_update_sequencer.md
CELLS_UPDATE_SEQUENCER -- requirements
Module: cells_update_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: width of a cell pattern word.
REQ-002 Parameter TMO_W, default 24: width of the timeout counter and of cfg_timeout.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-004 clock  in  1  sole clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req0_valid / req0_ready / req0_data  in/out/in  1/1/DATA_W  requester 0 (host register path) pattern handshake.
REQ-007 req1_valid / req1_ready / req1_data  in/out/in  1/1/DATA_W  requester 1 (pattern player) pattern handshake.
REQ-008 cfg_ccr0, cfg_ccr1  in  32 each  drive-window and sweep-period values for the cells controller.
REQ-009 cfg_passes  in  4  full sweeps per frame; 0 is treated as 1.
REQ-010 cfg_timeout  in  TMO_W  maximum RUN cycles; 0 disables the timeout.
REQ-011 force_full  in  1  force a full (non-differential) refresh on the next frame.
REQ-012 abort  in  1  terminate the current frame.
REQ-013 update_done  in  1  sweep-complete level from the cells controller.
REQ-014 cells_state  out  DATA_W  latched pattern.
REQ-015 ccr0, ccr1  out  32 each  latched timing values.
REQ-016 system_enable_n, enable_sn  out  1 each  controller enable (active-low) and full-refresh select.
REQ-017 busy, grant_id, frame_done, aborted, timeout_err  out  1 each  status outputs.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, FINISH and ERR.
REQ-019 In IDLE: at most one reqN_ready SHALL be high, and only for the granted requester; ready SHALL be low in all other states.
REQ-020 Arbitration SHALL be round-robin: with a single valid requester, that requester is granted; with both valid, the requester not granted last is granted; the last-grant pointer resets to 1, so req0 wins the first tie.
REQ-021 On valid&ready the block SHALL latch data into cells_state, latch cfg_ccr0/cfg_ccr1 into ccr0/ccr1, record the grant in grant_id, and enter RUN on the next cycle; configuration is frozen for the whole frame.
REQ-022 In RUN, system_enable_n SHALL be 0 and busy SHALL be 1.
REQ-023 enable_sn SHALL be 1 throughout the first frame after reset, or throughout a frame for which force_full was sampled high in IDLE at acceptance; otherwise enable_sn SHALL be 0.
REQ-024 Sweep completion SHALL be counted on rising edges of update_done only, because the level persists for multiple cycles.
REQ-025 When the edge count equals max(cfg_passes,1), the FSM SHALL go to FINISH; FINISH SHALL last exactly one cycle with system_enable_n=1 and frame_done=1, then return to IDLE.
REQ-026 abort in RUN SHALL go to IDLE next cycle with system_enable_n=1 and a one-cycle pulse on aborted; abort in IDLE is ignored.
REQ-027 When abort and the final update_done edge occur in the same cycle, abort SHALL win.
REQ-028 The RUN cycle counter SHALL saturate and never wrap.
REQ-029 cells_state and ccr0/ccr1 SHALL hold their values after the frame until the next acceptance.
REQ-030 The edge counter SHALL be 4 bits and be cleared on every acceptance.

Reset
REQ-031 Reset SHALL force: state IDLE, system_enable_n=1, enable_sn=1, cells_state=0, ccr0=0, ccr1=0, busy=0, grant_id=0, frame_done=0, aborted=0, timeout_err=0, counters=0, first-frame flag=1.
REQ-032 Reset asserted mid-RUN SHALL take effect on the next edge, with no frame_done or aborted pulse.

Configuration
REQ-033 With SEQ_TIMEOUT_EN defined: if RUN cycles reach a nonzero cfg_timeout, the FSM SHALL enter ERR (system_enable_n=1, timeout_err=1 sticky) and leave ERR only by reset.
REQ-034 Without SEQ_TIMEOUT_EN: the timeout counter and ERR state SHALL be absent, timeout_err tied 0, cfg_timeout ignored; all ports remain present in both builds.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the DATA_W/TMO_W defaults, and the pattern word typedef.
REQ-036 The round-robin arbiter SHALL be one sub-module, rr_arbiter2, containing the 2-requester grant logic and last-grant pointer.

Verification
REQ-037 After reset, req0 sends 16'h03FF with cfg_passes=2 -> accepted in 1 cycle; enable_sn=1; frame_done after the 2nd update_done rising edge; system_enable_n=1 in FINISH.
REQ-038 req0 and req1 both valid with continuous frames -> grants alternate 0,1,0,1; grant_id matches each accepted frame.
REQ-039 A second frame without force_full -> enable_sn=0; the same frame with force_full=1 -> enable_sn=1.
REQ-040 update_done held high for 5 cycles with cfg_passes=1 -> exactly one pass counted, one frame_done pulse.
REQ-041 abort on the cycle of the final update_done edge -> aborted=1 for one cycle, frame_done=0, IDLE next cycle.
REQ-042 SEQ_TIMEOUT_EN, cfg_timeout=100, update_done held 0 -> ERR entered at RUN cycle 100, timeout_err sticky until reset; without the macro -> RUN persists and timeout_err=0.
